board_sram_arbiter: RTL and testbench
=====================================

BOARD_SRAM_ARBITER -- requirements
Module: board_sram_arbiter

Interface
REQ-001 The block SHALL have parameter depth, default 19, which sizes the board address.
REQ-002 The block SHALL have parameter x_width, default 10, which is the x-field MSB index.
REQ-003 The block SHALL have parameter MAX_HOLD, default 16, which is the maximum number of consecutive locked ownership cycles.
REQ-004 Address width AW SHALL equal depth+3 (22 bits by default); data width is 4 bits; the port count is 3.
REQ-005 clk  input  1  the single clock; all logic is rising-edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 req  input  3  per-requester access request; bit i belongs to requester i.
REQ-008 lock  input  3  per-requester request to keep ownership across accesses.
REQ-009 we  input  3  per-requester write enable (1 = write, 0 = read).
REQ-010 addr  input  3*AW  per-requester address; slice i is bits [i*AW +: AW].
REQ-011 wdata  input  12  per-requester write tile; slice i is bits [i*4 +: 4].
REQ-012 gnt  output  3  one-hot ownership, registered.
REQ-013 ack  output  3  access performed this cycle for requester i.
REQ-014 rvalid  output  3  read data for requester i is on rdata this cycle.
REQ-015 rdata  output  4  read tile, driven directly from sram_data_in.
REQ-016 sram_addr  output  AW  SRAM address.
REQ-017 sram_data_out  output  4  SRAM write data.
REQ-018 sram_en  output  1  SRAM access strobe.
REQ-019 sram_we  output  1  SRAM write strobe.
REQ-020 sram_data_in  input  4  SRAM read data, valid one cycle after a read strobe.

Function
REQ-021 The FSM SHALL have exactly three states: IDLE, OWN and PAUSE.
REQ-022 IDLE: when any req bit is set, the owner SHALL be chosen round-robin starting at rr_ptr (0..2), gnt SHALL be registered, the FSM SHALL go to OWN, and no SRAM access SHALL occur in this cycle.
REQ-023 OWN: sram_en = req[owner]; sram_addr, sram_we and sram_data_out SHALL come from the owner's slices; ack[owner] = req[owner]; non-owner inputs SHALL be ignored.
REQ-024 OWN exit conditions (any one): req[owner]=0; lock[owner]=0, in which case the access in that cycle is still performed; hold_cnt = MAX_HOLD-1.
REQ-025 On OWN exit, rr_ptr SHALL become (owner+1) mod 3, gnt SHALL clear the next cycle, and the FSM SHALL go to PAUSE.
REQ-026 hold_cnt SHALL be 0 on entry to OWN and SHALL increment on each OWN cycle; it saturates and is never compared outside OWN.
REQ-027 PAUSE SHALL last one cycle with sram_en=0 and gnt=0 (bus turnaround), then the FSM SHALL go to IDLE.
REQ-028 Latency: req rising in IDLE SHALL give gnt at +1 cycle and the first ack at +1 cycle; a read ack SHALL be followed by rvalid exactly one cycle later.
REQ-029 rvalid SHALL be registered from (ack & ~we); it fires even if ownership has ended that cycle.
REQ-030 sram_we SHALL be 1 only when sram_en=1 and we[owner]=1.
REQ-031 Simultaneous requests SHALL be resolved strictly by rr_ptr; with rr_ptr=2 and req=3'b011, requester 0 wins.
REQ-032 A requester SHALL NOT be granted again until the other active requesters have been served, guaranteeing a bound of 2*(MAX_HOLD+2) cycles.
REQ-033 Forced release at MAX_HOLD SHALL be identical to a voluntary release; the requester re-arbitrates normally.

Reset
REQ-034 While reset=1 at a clock edge, the next cycle SHALL have: state=IDLE, rr_ptr=0, hold_cnt=0, gnt=0, and the rvalid pipeline cleared.
REQ-035 Outputs ack, sram_en and sram_we SHALL be 0 for any cycle whose state is IDLE or PAUSE, so all are 0 after reset.
REQ-036 A reset during OWN SHALL abort ownership without any further SRAM strobe, and a pending rvalid SHALL be suppressed.

Structure
REQ-037 Shared package board_pkg SHALL hold the tile width (4), the port count (3), the AW derivation from depth, and the FSM state encoding.
REQ-038 One combinational sub-module, rr_pick3, SHALL take (req, rr_ptr) and return a one-hot winner and its index; all state SHALL reside in board_sram_arbiter.

Verification
REQ-039 Single read: reset, then req[1]=1, we=0, addr1=0x000405 for one ack -> gnt=3'b010 at +1 cycle, sram_addr=0x000405, rvalid[1] at +2 cycles, rdata = SRAM content; PAUSE follows.
REQ-040 Contention: req=3'b111 continuous, unlocked -> grant order 0,1,2,0, each grant for one cycle separated by PAUSE+IDLE.
REQ-041 Locked burst: requester 2 holds lock=1 and req=1, writing tile 4'h3 to 20 addresses -> exactly 16 acks, forced release, then requester 2 is re-granted after the pending requester 0 has been served.
REQ-042 Lock dropped mid-burst: requester 0 drops lock on its 5th access -> 5 acks total, rr_ptr=1 afterwards.
REQ-043 Reset mid-OWN: reset asserted the cycle after a read ack -> no rvalid pulse, sram_en=0, gnt=0, next grant starts at requester 0.
REQ-044 Write/read ordering: requester 0 writes 4'h7 @0x000010; then requester 1 reads the same address -> rdata=4'h7 with rvalid[1].

Source files
------------

// File: rtl/board_sram_arbiter_pkg.sv
// Shared definitions for the board SRAM arbiter: tile width, port count,
// address-width derivation and the ownership FSM encoding.
package board_pkg;

    localparam int TILE_W = 4;
    localparam int NPORT  = 3;

    // The board address carries three extra bits above the depth field.
    function automatic int aw_of(input int depth);
        return depth + 3;
    endfunction

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

endpackage

// File: rtl/board_sram_arbiter_rr_pick3.sv
// Combinational round-robin pick among three requesters, starting the
// search at rr_ptr and wrapping modulo three.
module rr_pick3
    import board_pkg::*;
(
    input  logic [NPORT-1:0] req,
    input  logic [1:0]       rr_ptr,
    output logic [NPORT-1:0] winner,
    output logic [1:0]       idx
);

    logic       found;
    logic [1:0] cand;

    always_comb begin
        winner = '0;
        idx    = 2'd0;
        found  = 1'b0;
        cand   = 2'd0;
        for (int k = 0; k < NPORT; k++) begin
            cand = 2'((int'(rr_ptr) + k) % NPORT);
            if (!found && req[cand]) begin
                found        = 1'b1;
                idx          = cand;
                winner[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/board_sram_arbiter.sv
// Three-port SRAM arbiter: round-robin ownership with optional lock,
// bounded hold time and a one-cycle bus turnaround after every release.
module board_sram_arbiter
    import board_pkg::*;
#(
    parameter int depth    = 19,
    parameter int x_width  = 10,
    parameter int MAX_HOLD = 16,
    localparam int AW      = aw_of(depth)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NPORT-1:0]          req,
    input  logic [NPORT-1:0]          lock,
    input  logic [NPORT-1:0]          we,
    input  logic [NPORT*AW-1:0]       addr,
    input  logic [NPORT*TILE_W-1:0]   wdata,
    output logic [NPORT-1:0]          gnt,
    output logic [NPORT-1:0]          ack,
    output logic [NPORT-1:0]          rvalid,
    output logic [TILE_W-1:0]         rdata,
    output logic [AW-1:0]             sram_addr,
    output logic [TILE_W-1:0]         sram_data_out,
    output logic                      sram_en,
    output logic                      sram_we,
    input  logic [TILE_W-1:0]         sram_data_in
);

    localparam int HW = $clog2(MAX_HOLD + 1);

    generate
        if (x_width >= AW) begin : g_bad_x_width
            $error("x_width must index inside the board address");
        end
    endgenerate

    state_t            state, state_nx;
    logic [1:0]        rr_ptr, rr_nx;
    logic [1:0]        owner, owner_nx;
    logic [HW-1:0]     hold_cnt, hold_nx;
    logic [NPORT-1:0]  gnt_q, gnt_nx;
    logic [NPORT-1:0]  rvalid_q;
    logic [NPORT-1:0]  ack_c;
    logic [NPORT-1:0]  pick_onehot;
    logic [1:0]        pick_idx;
    logic [AW-1:0]     own_addr;
    logic [TILE_W-1:0] own_wdata;
    logic              own_req, own_lock, own_we;

    rr_pick3 u_pick (
        .req    (req),
        .rr_ptr (rr_ptr),
        .winner (pick_onehot),
        .idx    (pick_idx)
    );

    always_comb begin
        own_addr  = addr[0 +: AW];
        own_wdata = wdata[0 +: TILE_W];
        case (owner)
            2'd1: begin
                own_addr  = addr[AW +: AW];
                own_wdata = wdata[TILE_W +: TILE_W];
            end
            2'd2: begin
                own_addr  = addr[2*AW +: AW];
                own_wdata = wdata[2*TILE_W +: TILE_W];
            end
            default: ;
        endcase
    end

    assign own_req  = req[owner];
    assign own_lock = lock[owner];
    assign own_we   = we[owner];

    always_comb begin
        state_nx = state;
        rr_nx    = rr_ptr;
        owner_nx = owner;
        hold_nx  = hold_cnt;
        gnt_nx   = gnt_q;
        ack_c    = '0;
        sram_en  = 1'b0;
        sram_we  = 1'b0;
        case (state)
            IDLE: begin
                if (|req) begin
                    owner_nx = pick_idx;
                    gnt_nx   = pick_onehot;
                    hold_nx  = '0;
                    state_nx = OWN;
                end
            end
            OWN: begin
                // A reset arriving mid-ownership must not emit one more strobe.
                if (own_req && !reset) begin
                    sram_en      = 1'b1;
                    sram_we      = own_we;
                    ack_c[owner] = 1'b1;
                end
                if (!own_req || !own_lock || hold_cnt == HW'(MAX_HOLD - 1)) begin
                    rr_nx    = (owner == 2'd2) ? 2'd0 : owner + 2'd1;
                    gnt_nx   = '0;
                    state_nx = PAUSE;
                end else if (hold_cnt != {HW{1'b1}}) begin
                    hold_nx = hold_cnt + 1'b1;
                end
            end
            PAUSE: begin
                gnt_nx   = '0;
                state_nx = IDLE;
            end
            default: begin
                gnt_nx   = '0;
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            rr_ptr   <= 2'd0;
            owner    <= 2'd0;
            hold_cnt <= '0;
            gnt_q    <= '0;
            rvalid_q <= '0;
        end else begin
            state    <= state_nx;
            rr_ptr   <= rr_nx;
            owner    <= owner_nx;
            hold_cnt <= hold_nx;
            gnt_q    <= gnt_nx;
            rvalid_q <= ack_c & ~we;
        end
    end

    assign gnt           = gnt_q;
    assign ack           = ack_c;
    assign rvalid        = rvalid_q & {NPORT{~reset}};
    assign rdata         = sram_data_in;
    assign sram_addr     = own_addr;
    assign sram_data_out = own_wdata;

endmodule

// File: tb/tb_board_sram_arbiter.sv
// Directed bench for board_sram_arbiter with a behavioural SRAM model.
module tb_board_sram_arbiter;
    import board_pkg::*;

    localparam int AW = aw_of(19);

    logic              clk;
    logic              reset;
    logic [2:0]        req, lock, we;
    logic [3*AW-1:0]   addr;
    logic [11:0]       wdata;
    logic [2:0]        gnt, ack, rvalid;
    logic [3:0]        rdata;
    logic [AW-1:0]     sram_addr;
    logic [3:0]        sram_data_out;
    logic              sram_en, sram_we;
    logic [3:0]        sram_data_in;

    board_sram_arbiter dut (
        .clk           (clk),
        .reset         (reset),
        .req           (req),
        .lock          (lock),
        .we            (we),
        .addr          (addr),
        .wdata         (wdata),
        .gnt           (gnt),
        .ack           (ack),
        .rvalid        (rvalid),
        .rdata         (rdata),
        .sram_addr     (sram_addr),
        .sram_data_out (sram_data_out),
        .sram_en       (sram_en),
        .sram_we       (sram_we),
        .sram_data_in  (sram_data_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Unwritten locations read back a fixed address-derived pattern.
    function automatic logic [3:0] iv(input logic [AW-1:0] a);
        return a[3:0] ^ a[7:4] ^ {2'b00, a[9:8]} ^ 4'h6;
    endfunction

    logic [3:0] mem     [0:1023];
    logic       written [0:1023];

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 1024; i++) written[i] <= 1'b0;
        end else if (sram_en) begin
            if (sram_we) begin
                mem[sram_addr[9:0]]     <= sram_data_out;
                written[sram_addr[9:0]] <= 1'b1;
            end else begin
                sram_data_in <= written[sram_addr[9:0]] ? mem[sram_addr[9:0]] : iv(sram_addr);
            end
        end
    end

    typedef struct {
        logic          rst;
        logic [2:0]    req, lock, we;
        logic [AW-1:0] a0, a1, a2;
        logic [11:0]   wd;
        logic [2:0]    g, ak, rv;
        logic          en, swe;
        logic [AW-1:0] ea;
        logic [3:0]    ed;
        logic          chk_rd;
        logic [3:0]    erd;
    } vec_t;

    vec_t          tbl[$];
    logic [AW-1:0] cur_a0, cur_a1, cur_a2;
    logic [11:0]   cur_wd;
    int            vec_cnt;
    int            miscompares;

    function automatic vec_t mk(input logic rst, input logic [2:0] rq, lk, w,
                                input logic [2:0] g, ak, rv, input logic en, swe,
                                input logic [AW-1:0] ea, input logic [3:0] ed,
                                input logic chk_rd, input logic [3:0] erd);
        vec_t v;
        v.rst = rst; v.req = rq; v.lock = lk; v.we = w;
        v.a0 = cur_a0; v.a1 = cur_a1; v.a2 = cur_a2; v.wd = cur_wd;
        v.g = g; v.ak = ak; v.rv = rv; v.en = en; v.swe = swe;
        v.ea = ea; v.ed = ed; v.chk_rd = chk_rd; v.erd = erd;
        return v;
    endfunction

    function automatic vec_t idle_v(input logic rst, input logic [2:0] rq, lk, w, rv,
                                    input logic chk_rd, input logic [3:0] erd);
        return mk(rst, rq, lk, w, 3'b000, 3'b000, rv, 1'b0, 1'b0, '0, 4'h0, chk_rd, erd);
    endfunction

    task automatic cmp(input string f, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            miscompares++;
            $display("FAIL vec %0d %s: got %0h want %0h", vec_cnt, f, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        @(negedge clk);
        reset = v.rst;
        req   = v.req;
        lock  = v.lock;
        we    = v.we;
        addr  = {v.a2, v.a1, v.a0};
        wdata = v.wd;
        #1;
        vec_cnt++;
        cmp("gnt",     32'(gnt),     32'(v.g));
        cmp("ack",     32'(ack),     32'(v.ak));
        cmp("rvalid",  32'(rvalid),  32'(v.rv));
        cmp("sram_en", 32'(sram_en), 32'(v.en));
        cmp("sram_we", 32'(sram_we), 32'(v.swe));
        if (v.en) begin
            cmp("sram_addr",     32'(sram_addr),     32'(v.ea));
            cmp("sram_data_out", 32'(sram_data_out), 32'(v.ed));
        end
        if (v.chk_rd) cmp("rdata", 32'(rdata), 32'(v.erd));
    endtask

    initial begin
        vec_cnt = 0; miscompares = 0;
        reset = 1'b1; req = '0; lock = '0; we = '0; addr = '0; wdata = '0;

        // Single read by requester 1, then rr_ptr=2 tie-break with req=011.
        cur_a0 = 22'h000100; cur_a1 = 22'h000405; cur_a2 = 22'h3FFFFF; cur_wd = 12'h5A3;
        tbl.push_back(idle_v(0, 3'b000, 3'b000, 3'b000, 3'b000, 0, 4'h0));
        tbl.push_back(idle_v(0, 3'b010, 3'b000, 3'b000, 3'b000, 0, 4'h0));
        tbl.push_back(mk(0, 3'b010, 3'b000, 3'b000, 3'b010, 3'b010, 3'b000, 1, 0, 22'h000405, 4'hA, 0, 4'h0));
        tbl.push_back(idle_v(0, 3'b000, 3'b000, 3'b000, 3'b010, 1, iv(22'h000405)));
        tbl.push_back(idle_v(0, 3'b011, 3'b000, 3'b000, 3'b000, 0, 4'h0));
        tbl.push_back(mk(0, 3'b011, 3'b000, 3'b000, 3'b001, 3'b001, 3'b000, 1, 0, 22'h000100, 4'h3, 0, 4'h0));
        tbl.push_back(idle_v(0, 3'b000, 3'b000, 3'b000, 3'b001, 1, iv(22'h000100)));
        tbl.push_back(idle_v(0, 3'b000, 3'b000, 3'b000, 3'b000, 0, 4'h0));

        // Contention: all three unlocked, grant order 0,1,2,0; requester 1 writes.
        tbl.push_back(idle_v(1, 3'b000, 3'b000, 3'b000, 3'b000, 0, 4'h0));
        tbl.push_back(idle_v(0, 3'b111, 3'b000, 3'b010, 3'b000, 0, 4'h0));
        tbl.push_back(mk(0, 3'b111, 3'b000, 3'b010, 3'b001, 3'b001, 3'b000, 1, 0, 22'h000100, 4'h3, 0, 4'h0));
        tbl.push_back(idle_v(0, 3'b111, 3'b000, 3'b010, 3'b001, 1, iv(22'h000100)));
        tbl.push_back(idle_v(0, 3'b111, 3'b000, 3'b010, 3'b000, 0, 4'h0));
        tbl.push_back(mk(0, 3'b111, 3'b000, 3'b010, 3'b010, 3'b010, 3'b000, 1, 1, 22'h000405, 4'hA, 0, 4'h0));
        tbl.push_back(idle_v(0, 3'b111, 3'b000, 3'b010, 3'b000, 0, 4'h0));
        tbl.push_back(idle_v(0, 3'b111, 3'b000, 3'b010, 3'b000, 0, 4'h0));
        tbl.push_back(mk(0, 3'b111, 3'b000, 3'b010, 3'b100, 3'b100, 3'b000, 1, 0, 22'h3FFFFF, 4'h5, 0, 4'h0));
        tbl.push_back(idle_v(0, 3'b111, 3'b000, 3'b010, 3'b100, 1, iv(22'h3FFFFF)));
        tbl.push_back(idle_v(0, 3'b111, 3'b000, 3'b010, 3'b000, 0, 4'h0));
        tbl.push_back(mk(0, 3'b111, 3'b000, 3'b010, 3'b001, 3'b001, 3'b000, 1, 0, 22'h000100, 4'h3, 0, 4'h0));
        tbl.push_back(idle_v(0, 3'b000, 3'b000, 3'b000, 3'b001, 1, iv(22'h000100)));
        tbl.push_back(idle_v(0, 3'b000, 3'b000, 3'b000, 3'b000, 0, 4'h0));

        // Write 7 @0x10 by requester 0, then read it back through requester 1.
        cur_a0 = 22'h000010; cur_a1 = 22'h000010; cur_a2 = 22'h000000; cur_wd = 12'h007;
        tbl.push_back(idle_v(1, 3'b000, 3'b000, 3'b000, 3'b000, 0, 4'h0));
        tbl.push_back(idle_v(0, 3'b001, 3'b000, 3'b001, 3'b000, 0, 4'h0));
        tbl.push_back(mk(0, 3'b001, 3'b000, 3'b001, 3'b001, 3'b001, 3'b000, 1, 1, 22'h000010, 4'h7, 0, 4'h0));
        tbl.push_back(idle_v(0, 3'b010, 3'b000, 3'b000, 3'b000, 0, 4'h0));
        tbl.push_back(idle_v(0, 3'b010, 3'b000, 3'b000, 3'b000, 0, 4'h0));
        tbl.push_back(mk(0, 3'b010, 3'b000, 3'b000, 3'b010, 3'b010, 3'b000, 1, 0, 22'h000010, 4'h0, 0, 4'h0));
        tbl.push_back(idle_v(0, 3'b000, 3'b000, 3'b000, 3'b010, 1, 4'h7));
        tbl.push_back(idle_v(0, 3'b000, 3'b000, 3'b000, 3'b000, 0, 4'h0));

        repeat (2) @(posedge clk);
        for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

        // Locked burst by requester 2: 16 acks, forced release, 0 served, 2 again.
        cur_a0 = 22'h000020; cur_a1 = 22'h000000; cur_a2 = 22'h000300; cur_wd = 12'h300;
        apply(idle_v(1, 3'b000, 3'b000, 3'b000, 3'b000, 0, 4'h0));
        apply(idle_v(0, 3'b100, 3'b100, 3'b100, 3'b000, 0, 4'h0));
        for (int k = 0; k < 16; k++) begin
            cur_a2 = 22'h000300 + AW'(k);
            apply(mk(0, 3'b101, 3'b100, 3'b100, 3'b100, 3'b100, 3'b000, 1, 1, cur_a2, 4'h3, 0, 4'h0));
        end
        cur_a2 = 22'h000310;
        apply(idle_v(0, 3'b101, 3'b100, 3'b100, 3'b000, 0, 4'h0));
        apply(idle_v(0, 3'b101, 3'b100, 3'b100, 3'b000, 0, 4'h0));
        apply(mk(0, 3'b101, 3'b100, 3'b100, 3'b001, 3'b001, 3'b000, 1, 0, 22'h000020, 4'h0, 0, 4'h0));
        apply(idle_v(0, 3'b101, 3'b100, 3'b100, 3'b001, 1, iv(22'h000020)));
        apply(idle_v(0, 3'b101, 3'b100, 3'b100, 3'b000, 0, 4'h0));
        apply(mk(0, 3'b101, 3'b100, 3'b100, 3'b100, 3'b100, 3'b000, 1, 1, 22'h000310, 4'h3, 0, 4'h0));
        apply(mk(0, 3'b000, 3'b000, 3'b000, 3'b100, 3'b000, 3'b000, 0, 0, '0, 4'h0, 0, 4'h0));
        apply(idle_v(0, 3'b000, 3'b000, 3'b000, 3'b000, 0, 4'h0));

        // Requester 0 drops lock on its 5th access; next grant goes to requester 1.
        cur_a0 = 22'h000040; cur_a1 = 22'h000041; cur_a2 = 22'h000042; cur_wd = 12'h000;
        apply(idle_v(1, 3'b000, 3'b000, 3'b000, 3'b000, 0, 4'h0));
        apply(idle_v(0, 3'b001, 3'b001, 3'b000, 3'b000, 0, 4'h0));
        for (int k = 0; k < 4; k++)
            apply(mk(0, 3'b001, 3'b001, 3'b000, 3'b001, 3'b001, (k == 0) ? 3'b000 : 3'b001,
                     1, 0, 22'h000040, 4'h0, 0, 4'h0));
        apply(mk(0, 3'b001, 3'b000, 3'b000, 3'b001, 3'b001, 3'b001, 1, 0, 22'h000040, 4'h0, 0, 4'h0));
        apply(idle_v(0, 3'b111, 3'b000, 3'b000, 3'b001, 1, iv(22'h000040)));
        apply(idle_v(0, 3'b111, 3'b000, 3'b000, 3'b000, 0, 4'h0));
        apply(mk(0, 3'b111, 3'b000, 3'b000, 3'b010, 3'b010, 3'b000, 1, 0, 22'h000041, 4'h0, 0, 4'h0));
        apply(idle_v(0, 3'b000, 3'b000, 3'b000, 3'b010, 1, iv(22'h000041)));

        // Reset right after a read ack: no rvalid, no strobe, arbitration restarts at 0.
        cur_a0 = 22'h000060; cur_a1 = 22'h000050; cur_a2 = 22'h000070; cur_wd = 12'h000;
        apply(idle_v(1, 3'b000, 3'b000, 3'b000, 3'b000, 0, 4'h0));
        apply(idle_v(0, 3'b010, 3'b010, 3'b000, 3'b000, 0, 4'h0));
        apply(mk(0, 3'b010, 3'b010, 3'b000, 3'b010, 3'b010, 3'b000, 1, 0, 22'h000050, 4'h0, 0, 4'h0));
        apply(mk(1, 3'b010, 3'b010, 3'b000, 3'b010, 3'b000, 3'b000, 0, 0, '0, 4'h0, 0, 4'h0));
        apply(idle_v(0, 3'b111, 3'b000, 3'b000, 3'b000, 0, 4'h0));
        apply(mk(0, 3'b111, 3'b000, 3'b000, 3'b001, 3'b001, 3'b000, 1, 0, 22'h000060, 4'h0, 0, 4'h0));
        apply(idle_v(0, 3'b000, 3'b000, 3'b000, 3'b001, 1, iv(22'h000060)));
        apply(idle_v(0, 3'b000, 3'b000, 3'b000, 3'b000, 0, 4'h0));

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompares);
        $finish;
    end

endmodule
